// File: rtl/terminal_pkg.sv
// ---------------------------------------------------------------------------
// terminal_pkg : port offsets, control codes and FSM type for terminal_writer
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package terminal_pkg;

  // Offsets from BASE_PORT of the five decoded CPU ports
  localparam logic [7:0] OFF_CHAR = 8'd0;
  localparam logic [7:0] OFF_ROW  = 8'd1;
  localparam logic [7:0] OFF_COL  = 8'd2;
  localparam logic [7:0] OFF_ATTR = 8'd3;
  localparam logic [7:0] OFF_CMD  = 8'd4;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [7:0] DEFAULT_ATTR = 8'h0F;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } term_state_t;

endpackage : terminal_pkg

`default_nettype wire

// File: rtl/terminal_writer.sv
// ---------------------------------------------------------------------------
// terminal_writer : CPU port-mapped text terminal writing a character memory
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module terminal_writer
  import terminal_pkg::*;
#(
  parameter int         COLS           = 80,
  parameter int         ROWS           = 30,
  parameter logic [7:0] BASE_PORT      = 8'h80,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  port_id,
  input  logic [7:0]  write_data,
  input  logic        write_strobe,
  output logic [11:0] mem_addr,
  output logic        mem_en,
  output logic [15:0] mem_data,
  output logic [7:0]  status,
  output logic [6:0]  cursor_col
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [7:0] COLS_B   = 8'(COLS);
  localparam logic [7:0] ROWS_B   = 8'(ROWS);

  term_state_t state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [7:0]  attr_q, attr_d;
  logic        mem_en_q, mem_en_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic        start_q, start_d;

  logic [7:0]  port_off;
  logic [4:0]  row_inc;
  logic [4:0]  row_step;
  logic [6:0]  col_step;
  logic        at_last_cell;

  assign port_off = port_id - BASE_PORT;
  assign row_inc  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;

  // Cursor position after one printable cell; shared by CHAR writes and the clear sweep
  assign col_step     = (col_q == LAST_COL) ? 7'd0 : col_q + 7'd1;
  assign row_step     = (col_q == LAST_COL) ? row_inc : row_q;
  assign at_last_cell = (col_q == LAST_COL) && (row_q == LAST_ROW);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    attr_d     = attr_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    start_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          state_d = ST_CLEAR;
          row_d   = 5'd0;
          col_d   = 7'd0;
        end else if (write_strobe) begin
          case (port_off)
            OFF_CHAR: begin
              case (write_data)
                CH_BS: col_d = (col_q == 7'd0) ? 7'd0 : col_q - 7'd1;
                CH_LF: begin
                  col_d = 7'd0;
                  row_d = row_inc;
                end
                CH_CR: col_d = 7'd0;
                default: begin
                  mem_en_d   = 1'b1;
                  mem_addr_d = {row_q, col_q};
                  mem_data_d = {attr_q, write_data};
                  col_d      = col_step;
                  row_d      = row_step;
                end
              endcase
            end
            OFF_ROW:  row_d  = (write_data >= ROWS_B) ? 5'd0 : write_data[4:0];
            OFF_COL:  col_d  = (write_data >= COLS_B) ? 7'd0 : write_data[6:0];
            OFF_ATTR: attr_d = write_data;
            OFF_CMD: begin
              if (write_data[0]) begin
                state_d = ST_CLEAR;
                row_d   = 5'd0;
                col_d   = 7'd0;
              end
            end
            default: ;
          endcase
        end
      end

      ST_CLEAR: begin
        // row/col double as the sweep address; they land on (0,0) after the last cell
        mem_en_d   = 1'b1;
        mem_addr_d = {row_q, col_q};
        mem_data_d = {attr_q, CH_SPACE};
        col_d      = col_step;
        row_d      = row_step;
        if (at_last_cell) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      row_q      <= 5'd0;
      col_q      <= 7'd0;
      attr_q     <= DEFAULT_ATTR;
      mem_en_q   <= 1'b0;
      mem_addr_q <= 12'd0;
      mem_data_q <= 16'd0;
      start_q    <= CLEAR_ON_RESET;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      attr_q     <= attr_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      start_q    <= start_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign status     = {(state_q == ST_CLEAR), 2'b00, row_q};
  assign cursor_col = col_q;

endmodule : terminal_writer

`default_nettype wire

// File: tb/tb_terminal_writer.sv
// ---------------------------------------------------------------------------
// tb_terminal_writer : vector table, clear sequences and randomized model check
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_terminal_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  port_id = 8'h00;
  logic [7:0]  write_data = 8'h00;
  logic        write_strobe = 1'b0;
  logic [11:0] mem_addr;
  logic        mem_en;
  logic [15:0] mem_data;
  logic [7:0]  status;
  logic [6:0]  cursor_col;

  int tests = 0;
  int fails = 0;

  logic [27:0] wq[$];

  typedef struct {
    logic [7:0]  port;
    logic [7:0]  data;
    int          nwr;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [4:0]  row;
    logic [6:0]  col;
  } vec_t;

  vec_t vt[$];

  terminal_writer #(
    .COLS(COLS), .ROWS(ROWS), .BASE_PORT(8'h80), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .write_data(write_data),
    .write_strobe(write_strobe), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_data(mem_data), .status(status), .cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_en === 1'b1) wq.push_back({mem_addr, mem_data});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sig(input int n, input logic [11:0] a, input logic [15:0] d,
                                      input logic [7:0] st, input logic [6:0] c);
    return {17'd0, 4'(n), a, d, st, c};
  endfunction

  function automatic logic [63:0] dut_sig();
    logic [27:0] e;
    e = (wq.size() > 0) ? wq[0] : 28'd0;
    return sig(wq.size(), e[27:16], e[15:0], status, cursor_col);
  endfunction

  task automatic write_port(input logic [7:0] p, input logic [7:0] d);
    @(negedge clk);
    port_id = p; write_data = d; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
    #1;
  endtask

  // Called 1 time unit after a negedge at which busy is expected high.
  task automatic measure_clear(input logic [7:0] attr, input int inject, input int abort_at,
                               input string tag);
    int cnt;
    int errs;
    logic [27:0] e;
    cnt = 0;
    wq.delete();
    while (status[7] === 1'b1 && cnt < 5000) begin
      cnt++;
      if (abort_at != 0 && cnt == abort_at) begin
        reset = 1'b1;
        @(negedge clk); #1;
        chk({tag, "_abort_outputs"}, {35'd0, mem_en, mem_addr, mem_data},
            64'd0);
        chk({tag, "_abort_status"}, {56'd0, status}, 64'd0);
        @(negedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        return;
      end
      if (inject != 0) begin
        if (cnt == inject)      begin port_id = 8'h80; write_data = 8'h55; write_strobe = 1'b1; end
        if (cnt == inject + 10) begin port_id = 8'h81; write_data = 8'h05; write_strobe = 1'b1; end
        if (cnt == inject + 20) begin port_id = 8'h84; write_data = 8'h01; write_strobe = 1'b1; end
        if (cnt == inject + 1 || cnt == inject + 11 || cnt == inject + 21) write_strobe = 1'b0;
      end
      @(negedge clk); #1;
    end
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'(CELLS));
    chk({tag, "_write_count"}, 64'(wq.size()), 64'(CELLS));
    errs = 0;
    for (int i = 0; i < wq.size(); i++) begin
      e = wq[i];
      if (e[27:16] !== {5'(i / COLS), 7'(i % COLS)} || e[15:0] !== {attr, 8'h20}) begin
        if (errs == 0)
          $display("FAIL %s_seq_entry: index %0d got %h expected %h", tag, i, e,
                   {5'(i / COLS), 7'(i % COLS), attr, 8'h20});
        errs++;
      end
    end
    chk({tag, "_sequence_errors"}, 64'(errs), 64'd0);
    chk({tag, "_cursor_after"}, {49'd0, status, cursor_col}, 64'd0);
    @(negedge clk); #1;
    chk({tag, "_no_trailing_write"}, 64'(wq.size()), 64'(CELLS));
    wq.delete();
  endtask

  initial begin
    int m_row, m_col, pos, k, nwr;
    logic [7:0] m_attr, p, d;
    logic [11:0] ea;
    logic [15:0] ed;
    logic [7:0] ctl [3];
    ctl[0] = 8'h08; ctl[1] = 8'h0A; ctl[2] = 8'h0D;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {35'd0, mem_en, mem_addr, mem_data}, 64'd0);
    chk("reset_status_col", {49'd0, status, cursor_col}, 64'd0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("busy_after_reset", {63'd0, status[7]}, 64'd1);
    measure_clear(8'h0F, 0, 0, "rst_clear");

    // Table-driven single-write vectors
    vt.push_back('{8'h80, 8'h41, 1, 12'h000, 16'h0F41, 5'd0,  7'd1});
    vt.push_back('{8'h82, 8'd79, 0, 12'h000, 16'h0000, 5'd0,  7'd79});
    vt.push_back('{8'h81, 8'd2,  0, 12'h000, 16'h0000, 5'd2,  7'd79});
    vt.push_back('{8'h80, 8'h5A, 1, 12'h14F, 16'h0F5A, 5'd3,  7'd0});
    vt.push_back('{8'h81, 8'd29, 0, 12'h000, 16'h0000, 5'd29, 7'd0});
    vt.push_back('{8'h82, 8'd5,  0, 12'h000, 16'h0000, 5'd29, 7'd5});
    vt.push_back('{8'h80, 8'h0A, 0, 12'h000, 16'h0000, 5'd0,  7'd0});
    vt.push_back('{8'h80, 8'h08, 0, 12'h000, 16'h0000, 5'd0,  7'd0});
    vt.push_back('{8'h82, 8'd10, 0, 12'h000, 16'h0000, 5'd0,  7'd10});
    vt.push_back('{8'h82, 8'd80, 0, 12'h000, 16'h0000, 5'd0,  7'd0});
    vt.push_back('{8'h81, 8'd7,  0, 12'h000, 16'h0000, 5'd7,  7'd0});
    vt.push_back('{8'h81, 8'd30, 0, 12'h000, 16'h0000, 5'd0,  7'd0});
    vt.push_back('{8'h82, 8'd3,  0, 12'h000, 16'h0000, 5'd0,  7'd3});
    vt.push_back('{8'h80, 8'h08, 0, 12'h000, 16'h0000, 5'd0,  7'd2});
    vt.push_back('{8'h80, 8'h0D, 0, 12'h000, 16'h0000, 5'd0,  7'd0});
    vt.push_back('{8'h83, 8'h3C, 0, 12'h000, 16'h0000, 5'd0,  7'd0});
    vt.push_back('{8'h80, 8'h21, 1, 12'h000, 16'h3C21, 5'd0,  7'd1});
    vt.push_back('{8'h85, 8'h41, 0, 12'h000, 16'h0000, 5'd0,  7'd1});
    vt.push_back('{8'h7F, 8'h41, 0, 12'h000, 16'h0000, 5'd0,  7'd1});
    vt.push_back('{8'h84, 8'h02, 0, 12'h000, 16'h0000, 5'd0,  7'd1});
    vt.push_back('{8'h81, 8'hFF, 0, 12'h000, 16'h0000, 5'd0,  7'd1});
    vt.push_back('{8'h82, 8'd127,0, 12'h000, 16'h0000, 5'd0,  7'd0});
    vt.push_back('{8'h81, 8'd29, 0, 12'h000, 16'h0000, 5'd29, 7'd0});
    vt.push_back('{8'h82, 8'd79, 0, 12'h000, 16'h0000, 5'd29, 7'd79});
    vt.push_back('{8'h80, 8'h7E, 1, 12'hECF, 16'h3C7E, 5'd0,  7'd0});
    wq.delete();
    for (int i = 0; i < vt.size(); i++) begin
      write_port(vt[i].port, vt[i].data);
      chk($sformatf("vec%0d", i), dut_sig(),
          sig(vt[i].nwr, vt[i].addr, vt[i].wdata, {3'b000, vt[i].row}, vt[i].col));
      wq.delete();
    end

    // Clear with new attribute
    write_port(8'h83, 8'h1E);
    write_port(8'h84, 8'h01);
    measure_clear(8'h1E, 0, 0, "attr_clear");

    // Writes issued while busy must be ignored
    write_port(8'h84, 8'h01);
    measure_clear(8'h1E, 50, 0, "busy_writes");
    write_port(8'h80, 8'h41);
    chk("attr_kept_after_busy", dut_sig(), sig(1, 12'h000, 16'h1E41, 8'h00, 7'd1));
    wq.delete();

    // Reset in the middle of a clear restarts a full clear
    write_port(8'h84, 8'h01);
    measure_clear(8'h1E, 0, 100, "abort");
    chk("busy_after_abort_release", {63'd0, status[7]}, 64'd1);
    measure_clear(8'h0F, 0, 0, "restart_clear");

    // Randomized writes against a linear-position reference model
    m_row = 0; m_col = 0; m_attr = 8'h0F;
    wq.delete();
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      nwr = 0; ea = 12'd0; ed = 16'd0;
      if (k <= 4) begin
        p = 8'h80;
        d = ($urandom_range(0, 3) == 0) ? ctl[$urandom_range(0, 2)] : 8'($urandom_range(0, 255));
        if (d == 8'h08) begin
          if (m_col > 0) m_col--;
        end else if (d == 8'h0A) begin
          m_col = 0; m_row = (m_row + 1) % ROWS;
        end else if (d == 8'h0D) begin
          m_col = 0;
        end else begin
          nwr = 1;
          ea = 12'(m_row * 128 + m_col);
          ed = {m_attr, d};
          pos = (m_row * COLS + m_col + 1) % CELLS;
          m_row = pos / COLS; m_col = pos % COLS;
        end
      end else if (k == 5) begin
        p = 8'h81; d = 8'($urandom_range(0, 40));
        m_row = (d < ROWS) ? int'(d) : 0;
      end else if (k == 6) begin
        p = 8'h82; d = 8'($urandom_range(0, 150));
        m_col = (d < COLS) ? int'(d) : 0;
      end else if (k == 7) begin
        p = 8'h83; d = 8'($urandom_range(0, 255));
        m_attr = d;
      end else if (k == 8) begin
        p = 8'($urandom_range(0, 255));
        if (p >= 8'h80 && p <= 8'h84) p = 8'h90;
        d = 8'($urandom_range(0, 255));
      end else begin
        p = 8'h84; d = 8'($urandom_range(0, 255)) & 8'hFE;
      end
      write_port(p, d);
      chk($sformatf("rand%0d_p%h_d%h", n, p, d), dut_sig(),
          sig(nwr, ea, ed, {3'b000, 5'(m_row)}, 7'(m_col)));
      wq.delete();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_terminal_writer

`default_nettype wire
